uart_frame_sender: RTL and testbench

Upstream feeder for the serial UART transmitter. Accepts an image byte stream over a valid/ready interface and buffers it in a small FIFO. Wraps each stream packet (terminated by `s_last`) into a frame: sync bytes 0xAA 0x55, then the payload, then an 8-bit checksum. Feeds the frame one byte at a time to the transmitter through its `T_EN` / `Data` / `Transmit_Done` handshake.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_frame_sender.sv | 122 ++++++++++++
 tb/tb_uart_frame_sender.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame path: controller states, default sync
// bytes and the per-frame byte overhead (two sync bytes plus checksum).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_LOAD,
        ST_PAY,
        ST_CKSUM,
        ST_DONE
    } tx_state_e;

    localparam logic [7:0] SYNC0_DEF      = 8'hAA;
    localparam logic [7:0] SYNC1_DEF      = 8'h55;
    localparam int         FRAME_OVERHEAD = 3;

    // States in which a byte is offered to the transmitter.
    function automatic logic is_send_state(input tx_state_e s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_PAY) || (s == ST_CKSUM);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port that always presents the
// current head entry (first-word fall-through), plus full/empty flags.
module sync_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [AW:0]       count;
    logic              do_wr;
    logic              do_rd;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_wr      = wr_en & ~full;
    assign do_rd      = rd_en & ~empty;
    assign rd_ptr_nxt = do_rd ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge Clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // A write landing on the slot that becomes the head is bypassed straight
    // into the output register, since the memory still holds stale data there.
    always_ff @(posedge Clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (do_wr && (wr_ptr == rd_ptr_nxt)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/uart_frame_sender.sv
// Buffers an upstream byte stream and wraps each packet as SYNC0 SYNC1
// payload checksum, handing bytes one at a time to the UART transmitter.
module uart_frame_sender
    import uart_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC0      = SYNC0_DEF,
    parameter logic [7:0] SYNC1      = SYNC1_DEF
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        T_EN,
    output logic [7:0]  Data,
    input  logic        Transmit_Done,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_len
);

    tx_state_e   state;
    tx_state_e   state_nxt;
    logic        done_q;
    logic        td_rise;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [8:0]  fifo_rd;
    logic [7:0]  byte_r;
    logic        last_r;
    logic [7:0]  sum;
    logic [15:0] len;
    logic        ten_nxt;
    logic [7:0]  data_nxt;

    sync_fifo #(
        .DATA_W (9),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .reset   (reset),
        .wr_en   (s_valid & s_ready),
        .wr_data ({s_last, s_data}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s_ready    = ~fifo_full & ~reset;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);
    // Only a fresh 0->1 edge completes a byte; a level left high from the
    // previous byte is ignored.
    assign td_rise    = Transmit_Done & ~done_q;

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        unique case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_HDR0;
            ST_HDR0:  if (td_rise) state_nxt = ST_HDR1;
            ST_HDR1:  if (td_rise) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_PAY;
                end
            end
            ST_PAY:   if (td_rise) state_nxt = last_r ? ST_CKSUM : ST_LOAD;
            ST_CKSUM: if (td_rise) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        // T_EN is dropped for the cycle following a completion so the
        // transmitter sees a clean gap between bytes.
        ten_nxt = is_send_state(state_nxt) && !(is_send_state(state) && td_rise);

        data_nxt = Data;
        unique case (state_nxt)
            ST_HDR0:  data_nxt = SYNC0;
            ST_HDR1:  data_nxt = SYNC1;
            ST_PAY:   data_nxt = fifo_pop ? fifo_rd[7:0] : byte_r;
            ST_CKSUM: data_nxt = sum;
            default:  data_nxt = Data;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            done_q    <= 1'b0;
            T_EN      <= 1'b0;
            Data      <= 8'h00;
            frame_len <= 16'h0000;
        end else begin
            state  <= state_nxt;
            done_q <= Transmit_Done;
            T_EN   <= ten_nxt;
            Data   <= data_nxt;
            if (state == ST_DONE) frame_len <= len;
        end
    end

    // Checksum and length restart at every frame start, so they need no reset.
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && state_nxt == ST_HDR0) begin
            sum <= 8'h00;
            len <= 16'h0000;
        end else if (fifo_pop) begin
            byte_r <= fifo_rd[7:0];
            last_r <= fifo_rd[8];
            sum    <= sum + fifo_rd[7:0];
            len    <= len + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Frame sender driven by directed packets, feeding a transmitter model
// (4 clocks per bit) whose serial line is decoded and scoreboarded.
module tb_uart_frame_sender;
    import uart_pkg::*;

    logic        Clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        T_EN;
    logic [7:0]  Data;
    logic        Transmit_Done;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_len;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] explen_q[$];
    logic [7:0]  pkt[$];
    bit          len_pend = 1'b0;
    bit          bp_seen  = 1'b0;

    always #5 Clk = ~Clk;

    uart_frame_sender #(
        .FIFO_DEPTH (16),
        .SYNC0      (8'hAA),
        .SYNC1      (8'h55)
    ) dut (
        .Clk           (Clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .T_EN          (T_EN),
        .Data          (Data),
        .Transmit_Done (Transmit_Done),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_len     (frame_len)
    );

    // Transmitter model: samples T_EN once per bit tick, start/8 data/stop.
    logic [1:0] tx_tick;
    logic       tx_busy;
    logic       tx_line;
    logic [8:0] tx_sh;
    logic [3:0] tx_nbits;

    always @(posedge Clk) begin
        if (reset) begin
            tx_tick       <= 2'd0;
            tx_busy       <= 1'b0;
            tx_line       <= 1'b1;
            tx_sh         <= 9'h1FF;
            tx_nbits      <= 4'd0;
            Transmit_Done <= 1'b0;
        end else begin
            tx_tick <= tx_tick + 2'd1;
            if (tx_tick == 2'd3) begin
                if (!tx_busy) begin
                    if (T_EN) begin
                        tx_sh         <= {1'b1, Data};
                        tx_line       <= 1'b0;
                        tx_nbits      <= 4'd9;
                        tx_busy       <= 1'b1;
                        Transmit_Done <= 1'b0;
                    end
                end else if (tx_nbits != 4'd0) begin
                    tx_line  <= tx_sh[0];
                    tx_sh    <= {1'b1, tx_sh[8:1]};
                    tx_nbits <= tx_nbits - 4'd1;
                end else begin
                    tx_busy       <= 1'b0;
                    Transmit_Done <= 1'b1;
                end
            end
        end
    end

    // Line decoder and byte scoreboard.
    logic       rx_busy;
    int         rx_rc;
    logic [7:0] rx_sh;

    always @(posedge Clk) begin
        if (reset) begin
            rx_busy <= 1'b0;
            rx_rc   <= 0;
        end else if (!rx_busy) begin
            if (!tx_line) begin
                rx_busy <= 1'b1;
                rx_rc   <= 0;
            end
        end else begin
            rx_rc <= rx_rc + 1;
            if (rx_rc >= 5 && rx_rc <= 33 && ((rx_rc - 5) % 4) == 0)
                rx_sh <= {tx_line, rx_sh[7:1]};
            if (rx_rc == 37) begin
                rx_busy <= 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL line_byte unexpected actual=%02h required=none", rx_sh);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_sh !== e || tx_line !== 1'b1) begin
                        errors++;
                        $display("FAIL line_byte actual=%02h stop=%0b required=%02h stop=1",
                                 rx_sh, tx_line, e);
                    end
                end
            end
        end
    end

    // frame_done pulse monitor; frame_len is checked the cycle after the pulse.
    always @(negedge Clk) begin
        if (len_pend) begin
            logic [15:0] el;
            len_pend = 1'b0;
            el = explen_q.pop_front();
            checks++;
            if (frame_len !== el) begin
                errors++;
                $display("FAIL frame_len actual=%0d required=%0d", frame_len, el);
            end
        end
        if (frame_done) begin
            if (explen_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done unexpected pulse actual=1 required=0");
            end else begin
                len_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge Clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        if (!s_ready) bp_seen = 1'b1;
        while (!s_ready && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=s_ready_low required=s_ready_high");
        end
        @(posedge Clk);
    endtask

    task automatic release_bus();
        @(negedge Clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Expected line bytes: sync pair, payload, hand-supplied checksum.
    task automatic send_pkt(input logic [7:0] ck);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        exp_q.push_back(ck);
        explen_q.push_back(16'(pkt.size()));
        for (int i = 0; i < pkt.size(); i++) push(pkt[i], i == pkt.size() - 1);
        release_bus();
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || explen_q.size() != 0 || len_pend || busy) && n < limit) begin
            @(negedge Clk);
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(n >= limit), 32'd0);
    endtask

    task automatic wait_exp_empty(input string nm, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge Clk);
            n++;
        end
        chk({nm, "_bytes_timeout"}, 32'(n >= limit), 32'd0);
    endtask

    initial begin
        logic [7:0] ck;
        int bad;
        int n;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_T_EN", 32'(T_EN), 32'd0);
        chk("rst_Data", 32'(Data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Basic three-byte frame.
        pkt = '{8'h01, 8'h02, 8'h03};
        send_pkt(8'h06);
        wait_drain("basic", 5000);

        // Single-byte packet.
        pkt = '{8'hFF};
        send_pkt(8'hFF);
        wait_drain("single", 5000);

        // Checksum wraps modulo 256.
        pkt = '{8'h80, 8'h90};
        send_pkt(8'h10);
        wait_drain("wrap", 5000);

        // Back-pressure: 20 bytes into a 16-deep FIFO without pause.
        pkt.delete();
        ck = 8'h00;
        for (int i = 0; i < 20; i++) begin
            pkt.push_back(8'(i * 7 + 3));
            ck = ck + 8'(i * 7 + 3);
        end
        bp_seen = 1'b0;
        send_pkt(ck);
        chk("bp_s_ready_fell", 32'(bp_seen), 32'd1);
        wait_drain("backpressure", 20000);

        // Underflow stall between payload bytes.
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        explen_q.push_back(16'd3);
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        release_bus();
        wait_exp_empty("stall", 5000);
        repeat (10) @(negedge Clk);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (T_EN || !tx_line) bad++;
        end
        chk("stall_line_idle_violations", 32'(bad), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h60);
        push(8'h30, 1'b1);
        release_bus();
        wait_drain("stall", 5000);

        // Reset during the second payload byte.
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h11);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        release_bus();
        wait_exp_empty("midrst", 5000);
        n = 0;
        while (!T_EN && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("midrst_pay_started", 32'(T_EN), 32'd1);
        repeat (12) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        chk("midrst_T_EN", 32'(T_EN), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge Clk);
        chk("midrst_fifo_empty_idle", 32'(busy), 32'd0);
        chk("midrst_T_EN_idle", 32'(T_EN), 32'd0);

        pkt = '{8'h42};
        send_pkt(8'h42);
        wait_drain("after_rst", 5000);

        chk("left_bytes", 32'(exp_q.size()), 32'd0);
        chk("left_frames", 32'(explen_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
